// File: rtl/spi_slave_frame_rx.sv
// SPI mode-3 responder for a 4-byte LSB-first register-write frame, oversampled on clk40M.
// Optional readback path (MISO, read request) is built when SPI_SLAVE_READBACK_EN is defined.
module spi_slave_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BYTES  = 2,
  parameter int DATA_BYTES  = 2,
  parameter int RD_LATENCY  = 2
) (
  input  logic                    clk40M,
  input  logic                    rst,
  input  logic                    spi_clk,
  input  logic                    sl,
  input  logic                    mosi,
  output logic                    miso,
  output logic [8*ADDR_BYTES-1:0] o_addr,
  output logic [8*DATA_BYTES-1:0] o_wdata,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic                    o_frame_err,
  output logic                    o_overrun,
  output logic                    o_rd_req,
  output logic [8*ADDR_BYTES-1:0] o_rd_addr,
  input  logic [8*DATA_BYTES-1:0] i_rdata
);

  localparam int FBITS = 8 * (ADDR_BYTES + DATA_BYTES);
  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int CW    = $clog2(FBITS + 2);
  localparam logic [CW-1:0] CNT_FULL      = CW'(FBITS);
  localparam logic [CW-1:0] CNT_SAT       = CW'(FBITS + 1);
  localparam logic [CW-1:0] CNT_ADDR      = CW'(AW);
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(AW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sl_sync_q, mosi_sync_q, flush_q;
  logic                   sck_prev_q, sl_prev_q, armed_q;
  logic                   sck_s, sl_s, mosi_s, sck_rise, sl_fall, sl_rise, shift_en;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FBITS-1:0] shreg_q, shreg_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             wr_valid_q, wr_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Sync chains preset idle-high for SCK/CS so reset release creates no spurious edges.
  // armed_q keeps a CS already low at reset release from being taken as a frame start.
  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '1;
      sl_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b1;
      sl_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      sl_sync_q   <= {sl_sync_q[SYNC_STAGES-2:0], sl};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      sl_prev_q   <= sl_s;
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      if (flush_q[SYNC_STAGES-1] && sl_s) armed_q <= 1'b1;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sl_s     = sl_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sl_fall  = ~sl_s & sl_prev_q;
  assign sl_rise  = sl_s & ~sl_prev_q;
  assign shift_en = (state_q == SHIFT) && sck_rise && (cnt_q < CNT_FULL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_valid_d  = wr_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (wr_valid_q && i_wr_ready) wr_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sl_fall && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // A bit arriving with CS release is still shifted; COMMIT sees the final count.
        if (sck_rise && cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        if (shift_en) shreg_d = {mosi_s, shreg_q[FBITS-1:1]};
        if (sl_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL) begin
          if (!wr_valid_q || i_wr_ready) begin
            addr_d     = shreg_q[AW-1:0];
            wdata_d    = shreg_q[FBITS-1:AW];
            wr_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk40M) begin
    shreg_q <= shreg_d;
  end

  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

`ifdef SPI_SLAVE_READBACK_EN
  logic                  rd_req_q, rd_req_d, miso_q, miso_d, sck_fall, data_phase;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;
  logic [DW-1:0]         tx_q, tx_d;

  assign sck_fall   = ~sck_s & sck_prev_q;
  assign data_phase = (state_q == SHIFT) && (cnt_q >= CNT_ADDR) && (cnt_q < CNT_FULL);

  // Read request fires as the last address bit lands; the reply is latched RD_LATENCY later.
  always_comb begin
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    if (shift_en && cnt_q == CNT_ADDR_LAST) begin
      rd_req_d  = 1'b1;
      rd_addr_d = shreg_d[FBITS-1 -: AW];
    end
    if (rd_pipe_q[RD_LATENCY-1]) tx_d = i_rdata;
    if (!data_phase) begin
      miso_d = 1'b0;
    end else if (sck_fall) begin
      miso_d = tx_q[0];
      tx_d   = tx_q >> 1;
    end
  end

  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_pipe_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      rd_pipe_q <= (rd_pipe_q << 1) | RD_LATENCY'(rd_req_q);
      miso_q    <= miso_d;
    end
  end

  always_ff @(posedge clk40M) begin
    tx_q <= tx_d;
  end

  assign miso      = miso_q;
  assign o_rd_req  = rd_req_q;
  assign o_rd_addr = rd_addr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^{i_rdata, (RD_LATENCY > 0)};
  assign miso         = 1'b0;
  assign o_rd_req     = 1'b0;
  assign o_rd_addr    = '0;
`endif

endmodule
